ball_motion_ctrl: RTL

//  Sequences the ball position/velocity datapath. Launches the ball from a loaded

---
 rtl/ball_motion_if.sv | 36 +++
 rtl/ball_motion_ctrl.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/ball_motion_if.sv
`default_nettype none
// ============================================================================
//  Module   : ball_motion_if
//  Brief    : Control/status bundle between game control and ball_motion_ctrl.
//  Revision : 1.0 - initial release
// ============================================================================
interface ball_motion_if #(
    parameter int W  = 10,
    parameter int VW = 4
) ();
    logic          start;
    logic          stop;
    logic          pause;
    logic [W-1:0]  init_x;
    logic [W-1:0]  init_y;
    logic [VW-1:0] init_vx;
    logic [VW-1:0] init_vy;
    logic [W-1:0]  pos_x;
    logic [W-1:0]  pos_y;
    logic [VW-1:0] vel_x;
    logic [VW-1:0] vel_y;
    logic          moving;
    logic          bounce_x;
    logic          bounce_y;

    modport master (
        output start, stop, pause, init_x, init_y, init_vx, init_vy,
        input  pos_x, pos_y, vel_x, vel_y, moving, bounce_x, bounce_y
    );

    modport slave (
        input  start, stop, pause, init_x, init_y, init_vx, init_vy,
        output pos_x, pos_y, vel_x, vel_y, moving, bounce_x, bounce_y
    );
endinterface
`default_nettype wire

// File: rtl/ball_motion_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : ball_motion_ctrl
//  Brief    : Ball launch/advance/reflect sequencer, one update per frame tick.
//             Optional gravity on vel_y when BALL_GRAVITY_EN is defined.
//  Revision : 1.0 - initial release
// ============================================================================
module ball_motion_ctrl #(
    parameter int W        = 10,
    parameter int VW       = 4,
    parameter int X_MAX    = 639,
    parameter int Y_MAX    = 479,
    parameter int TICK_DIV = 833333,
    parameter int GRAV     = 1
) (
    input  wire          clk_50,
    input  wire          reset_n,
    ball_motion_if.slave bus
);
    localparam int             c_cnt_w   = $clog2(TICK_DIV);
    localparam logic [c_cnt_w-1:0] c_term = c_cnt_w'(TICK_DIV - 1);
    localparam logic [W-1:0]   c_x_max   = W'(X_MAX);
    localparam logic [W-1:0]   c_y_max   = W'(Y_MAX);
    localparam logic [VW-1:0]  c_vel_min = {1'b1, {(VW-1){1'b0}}};
    localparam logic [VW-1:0]  c_vel_max = {1'b0, {(VW-1){1'b1}}};

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_RUN    = 2'd2,
        S_PAUSED = 2'd3
    } state_t;

    typedef struct packed {
        logic [W-1:0]  pos;
        logic [VW-1:0] vel;
        logic          bounce;
    } axis_t;

    // The most negative velocity has no positive twin; clamp instead of wrapping.
    function automatic logic [VW-1:0] f_neg_sat(input logic [VW-1:0] v);
        return (v == c_vel_min) ? c_vel_max : (~v + 1'b1);
    endfunction

    function automatic axis_t f_axis(input logic [W-1:0]  pos,
                                     input logic [VW-1:0] vel,
                                     input logic [W-1:0]  lim);
        logic signed [W+1:0] n;
        axis_t               a;
        n        = $signed({2'b00, pos}) + $signed({{(W+2-VW){vel[VW-1]}}, vel});
        a.pos    = n[W-1:0];
        a.vel    = vel;
        a.bounce = 1'b0;
        if (n[W+1]) begin
            a.pos    = '0;
            a.vel    = f_neg_sat(vel);
            a.bounce = 1'b1;
        end else if (n[W:0] > {1'b0, lim}) begin
            a.pos    = lim;
            a.vel    = f_neg_sat(vel);
            a.bounce = 1'b1;
        end
        return a;
    endfunction

`ifdef BALL_GRAVITY_EN
    localparam logic signed [VW+1:0] c_grav        = (VW+2)'(GRAV);
    localparam logic signed [VW+1:0] c_vel_max_ext = {2'b00, c_vel_max};

    function automatic logic [VW-1:0] f_gravity(input logic [VW-1:0] v);
        logic signed [VW+1:0] s;
        s = $signed({{2{v[VW-1]}}, v}) + c_grav;
        return (s > c_vel_max_ext) ? c_vel_max : s[VW-1:0];
    endfunction
`endif

    state_t               r_state, w_state_nxt;
    logic [c_cnt_w-1:0]   r_cnt, w_cnt_nxt;
    logic [W-1:0]         r_pos_x, r_pos_y, w_pos_x_nxt, w_pos_y_nxt;
    logic [VW-1:0]        r_vel_x, r_vel_y, w_vel_x_nxt, w_vel_y_nxt;
    logic                 r_bounce_x, r_bounce_y, w_bounce_x_nxt, w_bounce_y_nxt;
    axis_t                w_ax, w_ay;

    assign w_ax = f_axis(r_pos_x, r_vel_x, c_x_max);
    assign w_ay = f_axis(r_pos_y, r_vel_y, c_y_max);

    always_ff @(posedge clk_50 or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= S_IDLE;
            r_cnt      <= '0;
            r_pos_x    <= '0;
            r_pos_y    <= '0;
            r_vel_x    <= '0;
            r_vel_y    <= '0;
            r_bounce_x <= 1'b0;
            r_bounce_y <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cnt      <= w_cnt_nxt;
            r_pos_x    <= w_pos_x_nxt;
            r_pos_y    <= w_pos_y_nxt;
            r_vel_x    <= w_vel_x_nxt;
            r_vel_y    <= w_vel_y_nxt;
            r_bounce_x <= w_bounce_x_nxt;
            r_bounce_y <= w_bounce_y_nxt;
        end
    end

    // stop beats pause beats tick; stop/pause cycles leave the count untouched.
    always_comb begin
        w_state_nxt    = r_state;
        w_cnt_nxt      = r_cnt;
        w_pos_x_nxt    = r_pos_x;
        w_pos_y_nxt    = r_pos_y;
        w_vel_x_nxt    = r_vel_x;
        w_vel_y_nxt    = r_vel_y;
        w_bounce_x_nxt = 1'b0;
        w_bounce_y_nxt = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (bus.start && !bus.stop) w_state_nxt = S_LOAD;
            end
            S_LOAD: begin
                w_pos_x_nxt = bus.init_x;
                w_pos_y_nxt = bus.init_y;
                w_vel_x_nxt = bus.init_vx;
                w_vel_y_nxt = bus.init_vy;
                w_cnt_nxt   = '0;
                w_state_nxt = bus.stop ? S_IDLE : S_RUN;
            end
            S_RUN: begin
                if (bus.stop) begin
                    w_state_nxt = S_IDLE;
                end else if (bus.pause) begin
                    w_state_nxt = S_PAUSED;
                end else if (r_cnt == c_term) begin
                    w_cnt_nxt      = '0;
                    w_pos_x_nxt    = w_ax.pos;
                    w_vel_x_nxt    = w_ax.vel;
                    w_bounce_x_nxt = w_ax.bounce;
                    w_pos_y_nxt    = w_ay.pos;
                    w_bounce_y_nxt = w_ay.bounce;
`ifdef BALL_GRAVITY_EN
                    w_vel_y_nxt    = f_gravity(w_ay.vel);
`else
                    w_vel_y_nxt    = w_ay.vel;
`endif
                end else begin
                    w_cnt_nxt = r_cnt + 1'b1;
                end
            end
            S_PAUSED: begin
                if (bus.stop)        w_state_nxt = S_IDLE;
                else if (!bus.pause) w_state_nxt = S_RUN;
            end
        endcase
    end

    assign bus.pos_x    = r_pos_x;
    assign bus.pos_y    = r_pos_y;
    assign bus.vel_x    = r_vel_x;
    assign bus.vel_y    = r_vel_y;
    assign bus.bounce_x = r_bounce_x;
    assign bus.bounce_y = r_bounce_y;
    assign bus.moving   = (r_state == S_RUN) || (r_state == S_PAUSED);

endmodule
`default_nettype wire
